// File: rtl/mcu_mem_pkg.sv
// Shared types and helpers for the MCU data memory.
// State encoding, read-during-write mode constants and the byte-lane merge.
package mcu_mem_pkg;

   typedef logic [0:0] state_t;

   localparam state_t S_CLEAR = 1'b0;
   localparam state_t S_READY = 1'b1;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;

   // The merge works on a wide fixed vector; callers zero-extend and truncate
   // to their own word width. Lanes beyond the caller's width have be=0.
   localparam int MERGE_W = 1024;
   localparam int MERGE_B = MERGE_W / 8;

   function automatic logic [MERGE_W-1:0] merge_be(
      input logic [MERGE_W-1:0] old_word,
      input logic [MERGE_W-1:0] wdata,
      input logic [MERGE_B-1:0] be
   );
      logic [MERGE_W-1:0] r;
      r = old_word;
      for (int k = 0; k < MERGE_B; k++) begin
         if (be[k]) r[8*k +: 8] = wdata[8*k +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/mcu_mem_clear_seq.sv
// Clear pointer for the post-reset memory wipe.
// Walks 0..DEPTH-1 while run is high; last flags the final index.
module mcu_mem_clear_seq
   import mcu_mem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   output logic [AW-1:0] ptr,
   output logic          last
);

   assign last = (ptr == AW'(DEPTH - 1));

   // Advance one word per cycle; a reset mid-clear restarts from index 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (run) begin
         ptr <= last ? '0 : ptr + 1'b1;
      end
   end

endmodule

// File: rtl/mcu_data_mem.sv
// MCU data memory: single-port, word-indexed, byte-lane strobes, 1-cycle
// registered response with out-of-range error.
// Optional macro MEM_CLEAR_EN: zero the whole array after every reset.
//
//   state   | meaning
//   S_CLEAR | wiping one word per cycle, requests refused
//   S_READY | accepting requests
module mcu_data_mem
   import mcu_mem_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 256,
   parameter int RDW_MODE = RDW_READ_FIRST
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [31:0]         req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state;
   logic              accept;
   logic              in_range;
   logic [AW-1:0]     idx;
   logic [DATA_W-1:0] old_word;
   logic [DATA_W-1:0] merged;
   logic              clr_we;
   logic [AW-1:0]     clr_ptr;

`ifdef MEM_CLEAR_EN
   logic clr_last;

   mcu_mem_clear_seq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clear_seq (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (state == S_CLEAR),
      .ptr   (clr_ptr),
      .last  (clr_last)
   );

   // Leave S_CLEAR once the last index has been written.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_CLEAR;
      end else if (state == S_CLEAR && clr_last) begin
         state <= S_READY;
      end
   end

   assign clr_we = rst_n && (state == S_CLEAR);
`else
   assign state   = S_READY;
   assign clr_we  = 1'b0;
   assign clr_ptr = '0;
`endif

   assign req_ready = (state == S_READY);
   assign accept    = req_valid && req_ready;

   // Full 32-bit compare so high address bits never alias into the array.
   assign in_range  = (req_addr < 32'(DEPTH));
   assign idx       = req_addr[AW-1:0];
   assign old_word  = mem[idx];
   assign merged    = DATA_W'(merge_be(MERGE_W'(old_word), MERGE_W'(req_wdata),
                                       MERGE_B'(req_be)));

   // Storage write port; intentionally unreset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_ptr] <= '0;
      end else if (rst_n && accept && req_we && in_range) begin
         mem[idx] <= merged;
      end
   end

   // Response register: pulse valid per accept, hold data/err otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= accept;
         if (accept) begin
            if (!in_range) begin
               rsp_rdata <= '0;
               rsp_err   <= 1'b1;
            end else begin
               rsp_err <= 1'b0;
               if (req_we && RDW_MODE == RDW_WRITE_FIRST) rsp_rdata <= merged;
               else                                       rsp_rdata <= old_word;
            end
         end
      end
   end

endmodule

// File: tb/tb_mcu_data_mem.sv
// Directed bench for mcu_data_mem: one READ_FIRST and one WRITE_FIRST
// instance driven by the same requests; clear sequence under MEM_CLEAR_EN.
module tb_mcu_data_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;

   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        wf_ready, wf_valid, wf_err;
   logic [31:0] wf_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mcu_data_mem #(.DATA_W(32), .DEPTH(256), .RDW_MODE(0)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   mcu_data_mem #(.DATA_W(32), .DEPTH(256), .RDW_MODE(1)) dut_wf (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(wf_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(wf_valid), .rsp_rdata(wf_rdata), .rsp_err(wf_err)
   );

`ifdef MEM_CLEAR_EN
   logic        c_rst_n, c_valid, c_we, c_ready, c_rvalid, c_err;
   logic [31:0] c_addr, c_wdata, c_rdata;
   logic [3:0]  c_be;

   mcu_data_mem #(.DATA_W(32), .DEPTH(16), .RDW_MODE(0)) dut_clr (
      .clk(clk), .rst_n(c_rst_n), .req_valid(c_valid), .req_ready(c_ready),
      .req_we(c_we), .req_addr(c_addr), .req_wdata(c_wdata), .req_be(c_be),
      .rsp_valid(c_rvalid), .rsp_rdata(c_rdata), .rsp_err(c_err)
   );
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one request at negedge; returns #1 after the accepting edge.
   task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      req_valid = 1'b0;
      req_we    = 1'b0;
   endtask

   logic [31:0] pre  [4];
   logic [31:0] nw   [4];
   int          cnt;

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
`ifdef MEM_CLEAR_EN
      c_rst_n = 1'b0;
      c_valid = 1'b0;
      c_we    = 1'b0;
      c_addr  = '0;
      c_wdata = '0;
      c_be    = '0;
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err",   {31'd0, rsp_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
`ifdef MEM_CLEAR_EN
      c_rst_n = 1'b1;
      cnt = 0;
      while (!req_ready && cnt < 400) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("init_clear_cycles", cnt, 32'd256);
`else
      #1;
      chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
`endif

      // 1: full write then read
      req(1'b1, 32'd5, 32'hDEADBEEF, 4'hF);
      chk("t1_wr_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t1_wr_err",   {31'd0, rsp_err}, 32'd0);
      req(1'b0, 32'd5, 32'h0, 4'h0);
      chk("t1_rd_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t1_rd_data",  rsp_rdata, 32'hDEADBEEF);
      chk("t1_rd_err",   {31'd0, rsp_err}, 32'd0);
      idle();
      @(posedge clk);
      #1;
      chk("t1_valid_drop", {31'd0, rsp_valid}, 32'd0);
      chk("t1_data_hold",  rsp_rdata, 32'hDEADBEEF);

      // 2: partial write and empty strobe
      req(1'b1, 32'd5, 32'h00001234, 4'h3);
      req(1'b0, 32'd5, 32'h0, 4'h0);
      chk("t2_partial", rsp_rdata, 32'hDEAD1234);
      req(1'b1, 32'd5, 32'hFFFFFFFF, 4'h0);
      chk("t2_be0_valid", {31'd0, rsp_valid}, 32'd1);
      req(1'b0, 32'd5, 32'h0, 4'h0);
      chk("t2_be0_unchanged", rsp_rdata, 32'hDEAD1234);

      // 3: read-during-write
      req(1'b1, 32'd7, 32'h11111111, 4'hF);
      req(1'b1, 32'd7, 32'h22222222, 4'hF);
      chk("t3_rdw_read_first",  rsp_rdata, 32'h11111111);
      chk("t3_rdw_write_first", wf_rdata,  32'h22222222);
      req(1'b1, 32'd7, 32'h000000AB, 4'h1);
      chk("t3_wf_merge", wf_rdata, 32'h222222AB);
      req(1'b0, 32'd7, 32'h0, 4'h0);
      chk("t3_rd_after", rsp_rdata, 32'h222222AB);

      // 4: out of range, boundaries untouched
      req(1'b1, 32'd0,   32'hA0A0A0A0, 4'hF);
      req(1'b1, 32'd255, 32'h55AA55AA, 4'hF);
      req(1'b0, 32'd256, 32'h0, 4'h0);
      chk("t4_oor_rd_err",  {31'd0, rsp_err}, 32'd1);
      chk("t4_oor_rd_data", rsp_rdata, 32'd0);
      chk("t4_oor_rd_valid", {31'd0, rsp_valid}, 32'd1);
      req(1'b1, 32'hFFFFFFFF, 32'hCAFEF00D, 4'hF);
      chk("t4_oor_wr_err",  {31'd0, rsp_err}, 32'd1);
      chk("t4_oor_wr_data", rsp_rdata, 32'd0);
      chk("t4_oor_wr_data_wf", wf_rdata, 32'd0);
      req(1'b0, 32'd255, 32'h0, 4'h0);
      chk("t4_a255", rsp_rdata, 32'h55AA55AA);
      chk("t4_a255_err", {31'd0, rsp_err}, 32'd0);
      req(1'b0, 32'd0, 32'h0, 4'h0);
      chk("t4_a0", rsp_rdata, 32'hA0A0A0A0);
      idle();

      // 5: streaming alternating write/read over addr 0..3
      for (int a = 0; a < 4; a++) begin
         pre[a] = 32'h00001000 + 32'(a);
         nw[a]  = 32'hC0DE0000 + 32'(a);
         req(1'b1, 32'(a), pre[a], 4'hF);
      end
      for (int i = 0; i < 8; i++) begin
         req(i[0] == 1'b0, 32'(i / 2), nw[i/2], 4'hF);
         chk($sformatf("t5_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
         if (i[0] == 1'b0) begin
            chk($sformatf("t5_wr_rf_%0d", i), rsp_rdata, pre[i/2]);
            chk($sformatf("t5_wr_wf_%0d", i), wf_rdata,  nw[i/2]);
         end else begin
            chk($sformatf("t5_rd_%0d", i), rsp_rdata, nw[i/2]);
         end
      end
      idle();
      @(posedge clk);
      #1;
      chk("t5_valid_drop", {31'd0, rsp_valid}, 32'd0);

`ifdef MEM_CLEAR_EN
      // 6: clear sequence on a 16-word instance
      for (int a = 0; a < 16; a++) begin
         @(negedge clk);
         c_valid = 1'b1; c_we = 1'b1; c_addr = 32'(a);
         c_wdata = 32'hA5A5A5A5; c_be = 4'hF;
      end
      @(negedge clk);
      c_valid = 1'b0; c_we = 1'b0;
      c_rst_n = 1'b0;
      @(negedge clk);
      c_rst_n = 1'b1;
      #1;
      cnt = 0;
      while (!c_ready && cnt < 100) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("t6_clear_cycles", cnt, 32'd16);
      for (int a = 0; a < 16; a++) begin
         @(negedge clk);
         c_valid = 1'b1; c_we = 1'b0; c_addr = 32'(a);
         @(posedge clk);
         #1;
         chk($sformatf("t6_zero_%0d", a), c_rdata, 32'd0);
      end
      @(negedge clk);
      c_valid = 1'b0;
      c_rst_n = 1'b0;
      @(negedge clk);
      c_rst_n = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      c_rst_n = 1'b0;
      @(negedge clk);
      c_rst_n = 1'b1;
      #1;
      cnt = 0;
      while (!c_ready && cnt < 100) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("t6_restart_cycles", cnt, 32'd16);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
